// File: rtl/cpu_scan_reader.sv
// Scan-chain reader for the toy CPU: walks the closed scan loop once
// and streams the sampled bits out LSB-first as bytes.
module cpu_scan_reader #(
  parameter int CHAIN_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       scan_en,
  input  logic       scan_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_in_byte;
  logic [7:0]    shreg, shreg_nx;
  logic [7:0]    byte_q;
  logic          valid_q, done_q, done_nx;
  logic          last_bit, completing, accept, en;

  assign last_bit   = (bit_cnt == LAST);
  assign completing = (bit_in_byte == 3'd7) | last_bit;
  assign accept     = valid_q & byte_ready;

  always_comb begin
    shreg_nx = shreg;
    shreg_nx[bit_in_byte] = scan_in;
  end

  always_comb begin
    state_nx = state;
    en       = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = SHIFT;
      end
      SHIFT: begin
        // Pause only when a finished byte has nowhere to go.
        en = !(completing & valid_q & !byte_ready);
        if (en & last_bit) state_nx = DRAIN;
      end
      DRAIN: begin
        if (accept) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_in_byte <= '0;
      shreg       <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= done_nx;
      if (en) begin
        bit_cnt     <= last_bit ? '0 : bit_cnt + CW'(1);
        bit_in_byte <= completing ? 3'd0 : bit_in_byte + 3'd1;
        // Cleared after each byte so a short last byte is zero-padded.
        shreg       <= completing ? 8'd0 : shreg_nx;
      end
      if (en & completing) begin
        byte_q  <= shreg_nx;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign scan_en    = en;
  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign done       = done_q;

endmodule
